// File: rtl/gf_arith_unit.sv
// GF(p) arithmetic unit: modular add, subtract, multiply and divide against a
// run-time odd prime. One shared datapath sits behind a start/done handshake.
module gf_arith_unit #(
    parameter int WIDTH = 33
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_prime,
    output logic [WIDTH-1:0] o_result,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);
    localparam int CW = $clog2(4 * WIDTH + 1);
    localparam logic [CW-1:0]    MULT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    STEP_MAX  = CW'(4 * WIDTH - 1);
    localparam logic [CW-1:0]    ONE_C     = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDSUB = 3'd1,
        MULT   = 3'd2,
        INV    = 3'd3,
        FIN    = 3'd4
    } state_t;

    state_t           state_r, state_nx;
    logic [WIDTH-1:0] a_r, b_r, p_r, acc_r, res_r;
    logic [WIDTH-1:0] u_r, v_r, x1_r, x2_r;
    logic [WIDTH-1:0] u_nx, v_nx, x1_nx, x2_nx, acc_nx;
    logic [WIDTH:0]   t_r;
    logic [CW-1:0]    cnt_r;
    logic             sub_r, phase_r, err_r;

    function automatic logic [WIDTH-1:0] reduce_once(input logic [WIDTH:0] t,
                                                     input logic [WIDTH-1:0] p);
        logic [WIDTH:0] d;
        d = t - {1'b0, p};
        if (t >= {1'b0, p}) return d[WIDTH-1:0];
        else                return t[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic [WIDTH-1:0] p);
        logic [WIDTH:0] t;
        t = {1'b0, x} + {1'b0, p} - {1'b0, y};
        return reduce_once(t, p);
    endfunction

    // Halving mod p: odd values get p added first so the shift is exact.
    function automatic logic [WIDTH-1:0] mod_half(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] p);
        logic [WIDTH:0] s;
        s = {1'b0, x} + (x[0] ? {1'b0, p} : {(WIDTH+1){1'b0}});
        return s[WIDTH:1];
    endfunction

    function automatic logic [WIDTH-1:0] mult_step(input logic [WIDTH-1:0] acc,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic             bit_in,
                                                   input logic [WIDTH-1:0] p);
        logic [WIDTH+1:0] pw, d, e;
        pw = {2'b00, p};
        d  = {1'b0, acc, 1'b0};
        if (d >= pw) d = d - pw;
        e  = d + (bit_in ? {2'b00, b} : {(WIDTH+2){1'b0}});
        if (e >= pw) e = e - pw;
        return e[WIDTH-1:0];
    endfunction

    // Next-value datapath for one multiply iteration and one inversion step
    always_comb begin
        acc_nx = mult_step(acc_r, b_r, a_r[WIDTH-1], p_r);
        u_nx   = u_r;
        v_nx   = v_r;
        x1_nx  = x1_r;
        x2_nx  = x2_r;
        if (!u_r[0]) begin
            u_nx  = u_r >> 1;
            x1_nx = mod_half(x1_r, p_r);
        end else if (!v_r[0]) begin
            v_nx  = v_r >> 1;
            x2_nx = mod_half(x2_r, p_r);
        end else if (u_r >= v_r) begin
            u_nx  = u_r - v_r;
            x1_nx = mod_sub(x1_r, x2_r, p_r);
        end else begin
            v_nx  = v_r - u_r;
            x2_nx = mod_sub(x2_r, x1_r, p_r);
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE: begin
                if (i_start) begin
                    case (i_op)
                        2'd0, 2'd1: state_nx = ADDSUB;
                        2'd2:       state_nx = MULT;
                        default: begin
                            if (i_b == '0 || i_b == ONE_W) state_nx = FIN;
                            else                           state_nx = INV;
                        end
                    endcase
                end else begin
                    state_nx = IDLE;
                end
            end
            ADDSUB: begin
                if (phase_r) state_nx = IDLE;
                else         state_nx = ADDSUB;
            end
            MULT: begin
                if (cnt_r == MULT_LAST) state_nx = FIN;
                else                    state_nx = MULT;
            end
            INV: begin
                if (u_nx == ONE_W || v_nx == ONE_W || cnt_r == STEP_MAX) state_nx = FIN;
                else                                                     state_nx = INV;
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst) state_r <= IDLE;
        else        state_r <= state_nx;
    end

    // Operand latching, iteration registers and registered outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            a_r      <= '0;
            b_r      <= '0;
            p_r      <= '0;
            acc_r    <= '0;
            res_r    <= '0;
            u_r      <= '0;
            v_r      <= '0;
            x1_r     <= '0;
            x2_r     <= '0;
            t_r      <= '0;
            cnt_r    <= '0;
            sub_r    <= 1'b0;
            phase_r  <= 1'b0;
            err_r    <= 1'b0;
            o_result <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (i_start) begin
                        a_r     <= i_a;
                        b_r     <= i_b;
                        p_r     <= i_prime;
                        sub_r   <= (i_op == 2'd1);
                        phase_r <= 1'b0;
                        cnt_r   <= '0;
                        acc_r   <= '0;
                        u_r     <= i_b;
                        v_r     <= i_prime;
                        x1_r    <= i_a;
                        x2_r    <= '0;
                        err_r   <= (i_op == 2'd3) && (i_b == '0);
                        // A unit divisor needs no inversion: the quotient is a.
                        res_r   <= ((i_op == 2'd3) && (i_b == ONE_W)) ? i_a : '0;
                        o_busy  <= 1'b1;
                    end
                end
                ADDSUB: begin
                    if (!phase_r) begin
                        t_r     <= sub_r ? ({1'b0, a_r} + {1'b0, p_r} - {1'b0, b_r})
                                         : ({1'b0, a_r} + {1'b0, b_r});
                        phase_r <= 1'b1;
                    end else begin
                        o_result <= reduce_once(t_r, p_r);
                        o_done   <= 1'b1;
                        o_busy   <= 1'b0;
                    end
                end
                MULT: begin
                    acc_r <= acc_nx;
                    a_r   <= a_r << 1;
                    cnt_r <= cnt_r + ONE_C;
                    if (cnt_r == MULT_LAST) res_r <= acc_nx;
                end
                INV: begin
                    u_r   <= u_nx;
                    v_r   <= v_nx;
                    x1_r  <= x1_nx;
                    x2_r  <= x2_nx;
                    cnt_r <= cnt_r + ONE_C;
                    if (u_nx == ONE_W)      res_r <= x1_nx;
                    else if (v_nx == ONE_W) res_r <= x2_nx;
                    else                    res_r <= '0;
                end
                FIN: begin
                    o_result <= res_r;
                    o_done   <= 1'b1;
                    o_err    <= err_r;
                    o_busy   <= 1'b0;
                end
                default: begin
                    o_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gf_arith_unit.sv
// Directed and model-checked bench for gf_arith_unit: results, latencies,
// handshake corner cases and mid-operation reset.
module tb_gf_arith_unit;
    localparam int WIDTH = 33;
    localparam logic [WIDTH-1:0] P23  = 33'd23;
    localparam logic [WIDTH-1:0] PM31 = 33'h0_7FFF_FFFF;
    localparam int               TMO  = 300;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       op = 2'd0;
    logic [WIDTH-1:0] a = '0, b = '0, p = '0;
    logic [WIDTH-1:0] result;
    logic             busy, done, err;
    int               checks = 0;
    int               errors = 0;

    gf_arith_unit #(.WIDTH(WIDTH)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op),
        .i_a(a), .i_b(b), .i_prime(p),
        .o_result(result), .o_busy(busy), .o_done(done), .o_err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge; returns at the negedge right after the accept edge.
    task automatic start_op(input logic [1:0] o, input logic [WIDTH-1:0] av, bv, pv);
        op = o; a = av; b = bv; p = pv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int from, output int lat);
        lat = from;
        while (done !== 1'b1 && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // exp_lat < 0 means only the 4*WIDTH step bound is checked.
    task automatic run(input string tag, input logic [1:0] o, input logic [WIDTH-1:0] av, bv, pv,
                       input logic [WIDTH-1:0] exp, input logic exp_err, input int exp_lat);
        int lat;
        start_op(o, av, bv, pv);
        check({tag, "_busy"}, WIDTH'(busy), WIDTH'(1));
        wait_done(0, lat);
        check({tag, "_done"}, WIDTH'(done), WIDTH'(1));
        check({tag, "_res"}, result, exp);
        check({tag, "_err"}, WIDTH'(err), WIDTH'(exp_err));
        check({tag, "_idle"}, WIDTH'(busy), WIDTH'(0));
        if (exp_lat >= 0) check({tag, "_lat"}, WIDTH'(lat), WIDTH'(exp_lat));
        else              check({tag, "_bound"}, WIDTH'(lat <= 4 * WIDTH + 1), WIDTH'(1));
    endtask

    function automatic longint unsigned powmod(input longint unsigned base_in,
                                               input longint unsigned e_in,
                                               input longint unsigned m);
        longint unsigned r, bs, e;
        r = 1; bs = base_in % m; e = e_in;
        while (e != 0) begin
            if (e[0]) r = (r * bs) % m;
            bs = (bs * bs) % m;
            e  = e >> 1;
        end
        return r;
    endfunction

    initial begin
        int lat;
        int ndone;
        longint unsigned ra, rb, rexp;

        repeat (3) @(negedge clk);
        check("rst_res", result, '0);
        check("rst_busy", WIDTH'(busy), WIDTH'(0));
        check("rst_done", WIDTH'(done), WIDTH'(0));
        check("rst_err", WIDTH'(err), WIDTH'(0));
        rst = 1'b1;

        // Consecutive runs start in the previous o_done cycle (back-to-back).
        run("add20_5", 2'd0, 33'd20, 33'd5, P23, 33'd2, 1'b0, 2);
        run("sub3_7",  2'd1, 33'd3,  33'd7, P23, 33'd19, 1'b0, 2);
        run("sub7_7",  2'd1, 33'd7,  33'd7, P23, 33'd0, 1'b0, 2);
        run("mul7_5",  2'd2, 33'd7,  33'd5, P23, 33'd12, 1'b0, WIDTH + 1);
        run("mul22_22", 2'd2, 33'd22, 33'd22, P23, 33'd1, 1'b0, WIDTH + 1);
        run("mul0_9",  2'd2, 33'd0,  33'd9, P23, 33'd0, 1'b0, WIDTH + 1);
        run("div1_5",  2'd3, 33'd1,  33'd5, P23, 33'd14, 1'b0, -1);
        run("div7_5",  2'd3, 33'd7,  33'd5, P23, 33'd6, 1'b0, -1);

        // Start pulse while a mult is running must be dropped.
        start_op(2'd2, 33'd3, 33'd4, P23);
        repeat (5) @(negedge clk);
        op = 2'd0; a = 33'd1; b = 33'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ign_hold", result, 33'd6);
        wait_done(6, lat);
        check("ign_res", result, 33'd12);
        check("ign_lat", WIDTH'(lat), WIDTH'(WIDTH + 1));
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("ign_nodone", WIDTH'(ndone), WIDTH'(0));

        run("div0_5",  2'd3, 33'd0, 33'd5, P23, 33'd0, 1'b0, -1);
        run("div9_0",  2'd3, 33'd9, 33'd0, P23, 33'd0, 1'b1, 1);
        run("div9_1",  2'd3, 33'd9, 33'd1, P23, 33'd9, 1'b0, -1);
        run("m31_mul", 2'd2, PM31 - 33'd1, PM31 - 33'd1, PM31, 33'd1, 1'b0, WIDTH + 1);
        run("m31_add", 2'd0, PM31 - 33'd1, PM31 - 33'd1, PM31, PM31 - 33'd2, 1'b0, 2);

        for (int k = 0; k < 100; k++) begin
            ra   = longint'($urandom % 32'h7FFF_FFFF);
            rb   = longint'($urandom % 32'h7FFF_FFFF);
            rexp = (ra * rb) % 64'h7FFF_FFFF;
            run("rnd_mul", 2'd2, WIDTH'(ra), WIDTH'(rb), PM31, WIDTH'(rexp), 1'b0, WIDTH + 1);
        end
        for (int k = 0; k < 100; k++) begin
            ra   = longint'($urandom % 32'h7FFF_FFFF);
            rb   = longint'(32'd1 + ($urandom % 32'h7FFF_FFFE));
            rexp = (ra * powmod(rb, 64'h7FFF_FFFD, 64'h7FFF_FFFF)) % 64'h7FFF_FFFF;
            run("rnd_div", 2'd3, WIDTH'(ra), WIDTH'(rb), PM31, WIDTH'(rexp), 1'b0, -1);
        end

        // Mid-operation reset: outputs clear and the aborted mult never completes.
        run("pre_rst", 2'd0, 33'd1, 33'd2, P23, 33'd3, 1'b0, 2);
        start_op(2'd2, 33'd7, 33'd5, P23);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("mrst_res", result, '0);
        check("mrst_busy", WIDTH'(busy), WIDTH'(0));
        check("mrst_done", WIDTH'(done), WIDTH'(0));
        check("mrst_err", WIDTH'(err), WIDTH'(0));
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("mrst_nodone", WIDTH'(ndone), WIDTH'(0));
        run("post_rst", 2'd0, 33'd1, 33'd1, P23, 33'd2, 1'b0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
